// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chess_pkg
// Description : Shared board encoding constants, FSM state type and nibble
//               access helpers for the chess datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package chess_pkg;

    localparam int SQ_W    = 6;
    localparam int BOARD_W = 256;
    localparam int PIECE_W = 4;

    // Piece type field (bits [2:0] of a square nibble)
    localparam logic [2:0] PT_EMPTY  = 3'd0;
    localparam logic [2:0] PT_PAWN   = 3'd1;
    localparam logic [2:0] PT_KNIGHT = 3'd2;
    localparam logic [2:0] PT_BISHOP = 3'd3;
    localparam logic [2:0] PT_ROOK   = 3'd4;
    localparam logic [2:0] PT_QUEEN  = 3'd5;
    localparam logic [2:0] PT_KING   = 3'd6;

    // Colour field (bit 3 of a square nibble)
    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT  = 3'd2,
        ST_APPLY = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Square n lives in bits [4n+3:4n]
    function automatic logic [PIECE_W-1:0] nibble_get(
        input logic [BOARD_W-1:0] board,
        input logic [SQ_W-1:0]    sq
    );
        return board[{sq, 2'b00} +: PIECE_W];
    endfunction

    function automatic logic [BOARD_W-1:0] nibble_set(
        input logic [BOARD_W-1:0] board,
        input logic [SQ_W-1:0]    sq,
        input logic [PIECE_W-1:0] val
    );
        logic [BOARD_W-1:0] b;
        b = board;
        b[{sq, 2'b00} +: PIECE_W] = val;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chess_move_apply_if.sv
`default_nettype none
// ============================================================================
// Module      : chess_move_apply_if
// Description : Move request handshake plus board memory port bundle.
//               slave = move-apply engine, master = requester/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface chess_move_apply_if #(
    parameter int ADDR_W = 1
);
    logic               req_valid;
    logic               req_ready;
    logic [5:0]         req_from;
    logic [5:0]         req_to;
    logic [2:0]         req_promo;
    logic               done;
    logic               err;
    logic [3:0]         captured;
    logic [ADDR_W-1:0]  mem_address;
    logic               mem_chipselect;
    logic               mem_clken;
    logic               mem_write;
    logic [255:0]       mem_writedata;
    logic [31:0]        mem_byteenable;
    logic [255:0]       mem_readdata;

    modport slave (
        input  req_valid, req_from, req_to, req_promo, mem_readdata,
        output req_ready, done, err, captured,
               mem_address, mem_chipselect, mem_clken, mem_write,
               mem_writedata, mem_byteenable
    );

    modport master (
        output req_valid, req_from, req_to, req_promo, mem_readdata,
        input  req_ready, done, err, captured,
               mem_address, mem_chipselect, mem_clken, mem_write,
               mem_writedata, mem_byteenable
    );
endinterface
`default_nettype wire

// File: rtl/chess_board_update.sv
`default_nettype none
// ============================================================================
// Module      : chess_board_update
// Description : Combinational move validation and board rewrite. Produces the
//               updated board, the captured piece and a reject flag.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_board_update
    import chess_pkg::*;
(
    input  wire logic [BOARD_W-1:0] board,
    input  wire logic [SQ_W-1:0]    from_sq,
    input  wire logic [SQ_W-1:0]    to_sq,
    input  wire logic [2:0]         promo,
    output logic      [BOARD_W-1:0] new_board,
    output logic      [PIECE_W-1:0] captured,
    output logic                    err
);

    logic [PIECE_W-1:0] src;
    logic [PIECE_W-1:0] dst;
    logic [PIECE_W-1:0] moved;
    logic               src_pawn;
    logic               last_rank;
    logic               promo_bad;

    // Validate the move and build the relocated board
    always_comb begin
        src       = nibble_get(board, from_sq);
        dst       = nibble_get(board, to_sq);
        src_pawn  = (src[2:0] == PT_PAWN);
        // White promotes on rank 8 (squares 56..63), black on rank 1 (0..7)
        last_rank = (src[3] == COLOR_BLACK) ? (to_sq[5:3] == 3'd0)
                                            : (to_sq[5:3] == 3'd7);
        promo_bad = (promo != 3'd0) && ((promo < PT_KNIGHT) || (promo > PT_QUEEN));

        err = (src[2:0] == PT_EMPTY)
           || (from_sq == to_sq)
           || ((dst[2:0] != PT_EMPTY) && (dst[3] == src[3]))
           || promo_bad
           || ((promo != 3'd0) && !src_pawn);

        // A promotion request off the last rank is simply ignored
        moved = (src_pawn && last_rank && (promo != 3'd0)) ? {src[3], promo} : src;

        if (err) begin
            new_board = board;
            captured  = '0;
        end else begin
            new_board = nibble_set(nibble_set(board, to_sq, moved), from_sq, '0);
            captured  = dst;
        end
    end

endmodule
`default_nettype wire

// File: rtl/chess_move_apply.sv
`default_nettype none
// ============================================================================
// Module      : chess_move_apply
// Description : Read-modify-write engine applying one chess move to the live
//               board word in the shared board memory.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_move_apply
    import chess_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 1,
    parameter int BOARD_ADDR   = 0
)(
    input  wire logic           clk,
    input  wire logic           reset,
    chess_move_apply_if.slave   bus
);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [SQ_W-1:0]     from_q, from_d;
    logic [SQ_W-1:0]     to_q, to_d;
    logic [2:0]          promo_q, promo_d;
    logic [BOARD_W-1:0]  board_q, board_d;
    logic [BOARD_W-1:0]  new_board_q, new_board_d;
    logic                err_q, err_d;
    logic [PIECE_W-1:0]  cap_q, cap_d;

    logic [BOARD_W-1:0]  upd_board;
    logic [PIECE_W-1:0]  upd_cap;
    logic                upd_err;

    chess_board_update u_update (
        .board     (board_q),
        .from_sq   (from_q),
        .to_sq     (to_q),
        .promo     (promo_q),
        .new_board (upd_board),
        .captured  (upd_cap),
        .err       (upd_err)
    );

    // State and datapath registers; reset drops any in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            from_q      <= '0;
            to_q        <= '0;
            promo_q     <= '0;
            board_q     <= '0;
            new_board_q <= '0;
            err_q       <= 1'b0;
            cap_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            from_q      <= from_d;
            to_q        <= to_d;
            promo_q     <= promo_d;
            board_q     <= board_d;
            new_board_q <= new_board_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
        end
    end

    // Next state and datapath captures
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        from_d      = from_q;
        to_d        = to_q;
        promo_d     = promo_q;
        board_d     = board_q;
        new_board_d = new_board_q;
        err_d       = err_q;
        cap_d       = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    from_d  = bus.req_from;
                    to_d    = bus.req_to;
                    promo_d = bus.req_promo;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                cnt_d   = 3'd1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is valid exactly READ_LATENCY cycles after the strobe
                if (cnt_q == 3'(READ_LATENCY)) begin
                    board_d = bus.mem_readdata;
                    state_d = ST_APPLY;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_APPLY: begin
                new_board_d = upd_board;
                err_d       = upd_err;
                cap_d       = upd_cap;
                state_d     = upd_err ? ST_DONE : ST_WR;
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        bus.req_ready      = (state_q == ST_IDLE);
        bus.mem_chipselect = (state_q == ST_RD) || (state_q == ST_WR);
        bus.mem_write      = (state_q == ST_WR);
        bus.mem_byteenable = (state_q == ST_WR) ? 32'hFFFF_FFFF : 32'h0;
        bus.mem_writedata  = (state_q == ST_WR) ? new_board_q : '0;
        bus.done           = (state_q == ST_DONE);
        bus.err            = (state_q == ST_DONE) && err_q;
        bus.captured       = (state_q == ST_DONE) ? cap_q : 4'h0;
    end

    assign bus.mem_address = ADDR_W'(BOARD_ADDR);
    assign bus.mem_clken   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_chess_move_apply.sv
`default_nettype none
// ============================================================================
// Module      : tb_chess_move_apply
// Description : Directed self-checking bench for chess_move_apply, with one
//               instance at read latency 1 and one at read latency 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chess_move_apply;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chess_move_apply_if #(.ADDR_W(1)) u1 ();
    chess_move_apply_if #(.ADDR_W(1)) u3 ();

    chess_move_apply #(.READ_LATENCY(1), .ADDR_W(1), .BOARD_ADDR(0)) dut1 (
        .clk(clk), .reset(rst1), .bus(u1)
    );
    chess_move_apply #(.READ_LATENCY(3), .ADDR_W(1), .BOARD_ADDR(0)) dut3 (
        .clk(clk), .reset(rst3), .bus(u3)
    );

    // Memory models: board is presented only in the cycle it is due, all-F otherwise
    logic [255:0] mem1, mem3;
    logic [3:0]   vld1 = '0, vld3 = '0;
    always @(posedge clk) begin
        vld1 <= {vld1[2:0], u1.mem_chipselect && !u1.mem_write};
        vld3 <= {vld3[2:0], u3.mem_chipselect && !u3.mem_write};
    end
    assign u1.mem_readdata = vld1[0] ? mem1 : {256{1'b1}};
    assign u3.mem_readdata = vld3[2] ? mem3 : {256{1'b1}};

    // Event monitors sampled on the falling edge
    int hs1 = 0, wr1 = 0, dn1 = 0, t01 = 0, wc1 = 0, dc1 = 0;
    int hs3 = 0, wr3 = 0, dn3 = 0, t03 = 0, wc3 = 0, dc3 = 0;
    logic [255:0] wd1, wd3;
    logic [31:0]  wbe1;
    logic         derr1, derr3;
    logic [3:0]   dcap1, dcap3;
    always @(negedge clk) begin
        if (u1.req_valid && u1.req_ready) begin hs1++; t01 = cyc; end
        if (u1.mem_chipselect && u1.mem_write) begin
            wr1++; wc1 = cyc; wd1 = u1.mem_writedata; wbe1 = u1.mem_byteenable;
        end
        if (u1.done) begin dn1++; dc1 = cyc; derr1 = u1.err; dcap1 = u1.captured; end
        if (u3.req_valid && u3.req_ready) begin hs3++; t03 = cyc; end
        if (u3.mem_chipselect && u3.mem_write) begin wr3++; wc3 = cyc; wd3 = u3.mem_writedata; end
        if (u3.done) begin dn3++; dc3 = cyc; derr3 = u3.err; dcap3 = u3.captured; end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] pc);
        logic [255:0] r;
        r = b;
        r[sq*4 +: 4] = pc;
        return r;
    endfunction

    typedef struct {
        string        name;
        logic [255:0] board;
        logic [5:0]   from_sq;
        logic [5:0]   to_sq;
        logic [2:0]   promo;
        logic         exp_err;
        logic [3:0]   exp_cap;
        logic [255:0] exp_board;
    } vec_t;

    vec_t vecs[14];

    // One request on the latency-1 instance, with all checks
    task automatic run1(input vec_t v);
        int hb, wb, db;
        hb = hs1; wb = wr1; db = dn1;
        mem1 = v.board;
        @(posedge clk); #1;
        u1.req_valid = 1'b1; u1.req_from = v.from_sq; u1.req_to = v.to_sq; u1.req_promo = v.promo;
        @(posedge clk); #1;
        u1.req_valid = 1'b0;
        for (int i = 0; i < 20 && dn1 == db; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({v.name, " handshake"}, 256'(hs1 - hb), 256'd1);
        chk({v.name, " done"}, 256'(dn1 - db), 256'd1);
        chk({v.name, " err"}, 256'(derr1), 256'(v.exp_err));
        chk({v.name, " captured"}, 256'(dcap1), 256'(v.exp_cap));
        chk({v.name, " done latency"}, 256'(dc1 - t01), v.exp_err ? 256'd4 : 256'd5);
        if (v.exp_err) begin
            chk({v.name, " no write"}, 256'(wr1 - wb), 256'd0);
        end else begin
            chk({v.name, " one write"}, 256'(wr1 - wb), 256'd1);
            chk({v.name, " write latency"}, 256'(wc1 - t01), 256'd4);
            chk({v.name, " writedata"}, wd1, v.exp_board);
            chk({v.name, " byteenable"}, 256'(wbe1), 256'hFFFF_FFFF);
        end
    endtask

    initial begin
        logic [255:0] bg;
        int wb, db, hb;

        rst1 = 1'b1; rst3 = 1'b1;
        u1.req_valid = 1'b0; u1.req_from = '0; u1.req_to = '0; u1.req_promo = '0;
        u3.req_valid = 1'b0; u3.req_from = '0; u3.req_to = '0; u3.req_promo = '0;
        mem1 = '0; mem3 = '0;

        bg = put(put(put(256'd0, 7, 4'h4), 56, 4'hC), 62, 4'hE);
        vecs[0]  = '{"pawn push",      put(bg,12,4'h1),                 12, 28, 3'd0, 1'b0, 4'h0, put(bg,28,4'h1)};
        vecs[1]  = '{"bishop capture", put(put(bg,28,4'hA),19,4'h3),    19, 28, 3'd0, 1'b0, 4'hA, put(bg,28,4'h3)};
        vecs[2]  = '{"empty source",   bg,                               0,  8, 3'd0, 1'b1, 4'h0, bg};
        vecs[3]  = '{"own capture",    put(put(bg,0,4'h4),4,4'h6),       0,  4, 3'd0, 1'b1, 4'h0, bg};
        vecs[4]  = '{"promo queen",    put(bg,52,4'h1),                 52, 60, 3'd5, 1'b0, 4'h0, put(bg,60,4'h5)};
        vecs[5]  = '{"promo 7",        put(bg,52,4'h1),                 52, 60, 3'd7, 1'b1, 4'h0, bg};
        vecs[6]  = '{"from eq to",     put(bg,10,4'h2),                 10, 10, 3'd0, 1'b1, 4'h0, bg};
        vecs[7]  = '{"black promo",    put(bg,10,4'h9),                 10,  2, 3'd4, 1'b0, 4'h0, put(bg,2,4'hC)};
        vecs[8]  = '{"last rank nopro",put(bg,52,4'h1),                 52, 60, 3'd0, 1'b0, 4'h0, put(bg,60,4'h1)};
        vecs[9]  = '{"knight promo",   put(bg,1,4'h2),                   1, 18, 3'd5, 1'b1, 4'h0, bg};
        vecs[10] = '{"black capture",  put(put(bg,40,4'hD),8,4'h1),     40,  8, 3'd0, 1'b0, 4'h1, put(bg,8,4'hD)};
        vecs[11] = '{"promo 1",        put(bg,52,4'h1),                 52, 60, 3'd1, 1'b1, 4'h0, bg};
        vecs[12] = '{"promo midboard", put(bg,12,4'h1),                 12, 20, 3'd3, 1'b0, 4'h0, put(bg,20,4'h1)};
        vecs[13] = '{"black on black", put(bg,40,4'hD),                 40, 56, 3'd0, 1'b1, 4'h0, bg};

        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", 256'(u1.req_ready), 256'd1);
        rst1 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
        chk("rst outputs", {u1.req_ready, u1.done, u1.err, u1.captured, u1.mem_chipselect,
                            u1.mem_write, u1.mem_clken, u1.mem_byteenable},
                           {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0});
        chk("rst writedata", u1.mem_writedata, 256'd0);
        chk("rst ready L3", 256'(u3.req_ready), 256'd1);

        foreach (vecs[i]) run1(vecs[i]);

        // Reset asserted while waiting for read data
        wb = wr1; db = dn1;
        mem1 = vecs[0].board;
        @(posedge clk); #1;
        u1.req_valid = 1'b1; u1.req_from = 6'd12; u1.req_to = 6'd28; u1.req_promo = 3'd0;
        @(posedge clk); #1;
        u1.req_valid = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("post-reset ready", 256'(u1.req_ready), 256'd1);
        chk("post-reset cs", 256'(u1.mem_chipselect), 256'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("reset no write", 256'(wr1 - wb), 256'd0);
        chk("reset no done", 256'(dn1 - db), 256'd0);
        run1(vecs[1]);

        // Latency 3 with valid held through the whole operation
        hb = hs3; wb = wr3; db = dn3;
        mem3 = vecs[1].board;
        @(posedge clk); #1;
        u3.req_valid = 1'b1; u3.req_from = 6'd19; u3.req_to = 6'd28; u3.req_promo = 3'd0;
        for (int i = 0; i < 30 && !u3.done; i++) begin
            @(posedge clk); #1;
        end
        u3.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("L3 handshakes", 256'(hs3 - hb), 256'd1);
        chk("L3 done", 256'(dn3 - db), 256'd1);
        chk("L3 done latency", 256'(dc3 - t03), 256'd7);
        chk("L3 write latency", 256'(wc3 - t03), 256'd6);
        chk("L3 one write", 256'(wr3 - wb), 256'd1);
        chk("L3 writedata", wd3, vecs[1].exp_board);
        chk("L3 err", 256'(derr3), 256'd0);
        chk("L3 captured", 256'(dcap3), 256'hA);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
